// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;

   localparam int SERIAL_SUB_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit full subtractor cell: d = a - b - bi, bo = borrow out
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - LSB-first bit-serial A - B - b_in through one full_sub cell
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int W = SERIAL_SUB_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         b_in,
   output logic         in_ready,
   output logic [W-1:0] diff,
   output logic         bor,
   output logic         out_valid,
   input  logic         out_ready
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = $clog2(W);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   a_sr_q, a_sr_d;
   logic [W-1:0]   b_sr_q, b_sr_d;
   logic [W-1:0]   diff_q, diff_d;
   logic           brw_q, brw_d;
   logic           bor_q, bor_d;
   logic           cell_d, cell_bo;
`ifdef SERIAL_SUB_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   full_sub u_cell (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .bi (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bor_d   = bor_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               brw_d   = b_in;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            diff_d = {cell_d, diff_q[W-1:1]};
            brw_d  = cell_bo;
            // Final bit: latch borrow-out; counter holds so it never wraps.
            if (cnt_q == CW'(W - 1)) begin
               bor_d   = cell_bo;
               state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d   = brw_q ^ cell_bo;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bor_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bor_q   <= bor_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bor       = bor_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized self-checking bench for serial_sub against an arithmetic model
module tb_serial_sub;
   import serial_sub_pkg::*;

   localparam int W = SERIAL_SUB_W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         b_in;
   logic         in_ready;
   logic [W-1:0] diff;
   logic         bor;
   logic         out_valid;
   logic         out_ready;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_sub #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .b_in      (b_in),
      .in_ready  (in_ready),
      .diff      (diff),
      .bor       (bor),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                        output logic [W-1:0] md, output logic mbo, output logic mov);
      int u, sa, sb, s;
      u   = int'(ma) - int'(mb) - int'(mbin);
      md  = W'(u);
      mbo = (u < 0);
      sa  = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
      sb  = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
      s   = sa - sb - int'(mbin);
      mov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
   endtask

   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         input int stall);
      logic [W-1:0] ed;
      logic         ebo, eov;
      int           lat;
      model(oa, ob, obin, ed, ebo, eov);
      @(posedge clk); #1;
      check("in_ready_idle", in_ready, 1);
      a = oa; b = ob; b_in = obin; start = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      check("in_ready_shift", in_ready, 0);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 4 * W);
      check("latency", lat, W);
      check("diff", diff, ed);
      check("bor", bor, ebo);
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", ovf, eov);
`endif
      for (int i = 0; i < stall; i++) begin
         start = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_diff", diff, ed);
         check("hold_bor", bor, ebo);
      end
      // Handshake cycle with a start pulse that must be ignored.
      start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_after_hs", in_ready, 1);
      check("valid_after_hs", out_valid, 0);
      check("diff_in_idle", diff, ed);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_bor", bor, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(8'h05, 8'h03, 1'b0, 0);
      run_op(8'h03, 8'h05, 1'b0, 0);
      run_op(8'h00, 8'h00, 1'b1, 0);
      run_op(8'h80, 8'h01, 1'b0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      run_op(8'h10, 8'h01, 1'b0, 5);

      // Abort mid-SHIFT: reset acts without waiting for a clock edge.
      @(posedge clk); #1;
      a = 8'hA5; b = 8'h3C; b_in = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_diff", diff, 0);
      check("abort_bor", bor, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(8'h09, 8'h04, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
